seg_scan_mux: RTL



---
 rtl/seg_scan_mux_pkg.sv | 30 +++
 rtl/seg_scan_mux_if.sv | 33 +++
 rtl/seg_scan_mux_bcd_to_seg.sv | 29 ++
 rtl/seg_scan_mux.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared 7-segment encoding for the display and the clock/counter datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_scan_mux_pkg;

  // Segment bus bit order: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [6:0] seg_t;

  // Active-high glyphs in the bit order above.
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bundle between the BCD datapath (master) and the display scanner (slave).
// Latency: n/a (wiring only).
// Backpressure: none; ena is the only flow control and freezes the scanner.
interface seg_scan_mux_if
  import seg_scan_mux_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int DIM_BITS = 3
);
  localparam int SEL_W = $clog2(DIGITS);

  logic                  ena;
  logic [4*DIGITS-1:0]   digits_bcd;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic                  lz_en;
  logic [DIM_BITS-1:0]   brightness;
  seg_t                  seg;
  logic                  dp;
  logic [SEL_W-1:0]      sel;
  logic                  frame_tick;

  modport master (
    output ena, digits_bcd, dp_mask, blink_mask, lz_en, brightness,
    input  seg, dp, sel, frame_tick
  );

  modport slave (
    input  ena, digits_bcd, dp_mask, blink_mask, lz_en, brightness,
    output seg, dp, sel, frame_tick
  );

endinterface

// File: rtl/seg_scan_mux_bcd_to_seg.sv
// BCD digit to 7-segment glyph; codes 10-15 render blank.
// Latency: combinational.
// Backpressure: none.
module seg_scan_mux_bcd_to_seg
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       glyph
);

  // Glyph lookup with blank as the fallback for non-decimal codes.
  always_comb begin
    glyph = SEG_BLANK;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: per-frame snapshot, LZ suppression, dp, blink, PWM dimming.
// Latency: sel/seg/dp/frame_tick are registered, one tick behind the (ptr, phase) scan state.
// Backpressure: none; ena low freezes all scan state and blanks seg/dp while sel holds.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int DIM_BITS   = 3,
  parameter int BLINK_BITS = 6
) (
  input  logic           clk_scan_to_light,
  input  logic           rst,
  seg_scan_mux_if.slave  bus
);

  localparam int SEL_W = $clog2(DIGITS);
  localparam logic [SEL_W-1:0]    PTR_LAST   = SEL_W'(DIGITS - 1);
  localparam logic [DIM_BITS-1:0] PHASE_LAST = '1;

  // Everything the display decisions depend on, frozen once per frame.
  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink;
    logic                lz;
    logic [DIM_BITS-1:0] bright;
  } snap_t;

  logic [SEL_W-1:0]      ptr;
  logic [DIM_BITS-1:0]   phase;
  logic [BLINK_BITS-1:0] frame_cnt;
  snap_t                 snap;
  logic                  wrap_pend;

  logic                  dwell_end;
  logic                  frame_wrap;
  logic [DIGITS-1:0]     zero_from;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;
  seg_t                  cur_glyph;
  logic                  visible;

  seg_t                  seg_q;
  logic                  dp_q;
  logic [SEL_W-1:0]      sel_q;
  logic                  frame_tick_q;

  assign dwell_end  = bus.ena && (phase == PHASE_LAST);
  assign frame_wrap = dwell_end && (ptr == PTR_LAST);

  // Scan pointer, dwell phase, frame counter and snapshot advance only while enabled.
  always_ff @(posedge clk_scan_to_light or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      phase     <= '0;
      frame_cnt <= '0;
      snap      <= '0;
    end else if (bus.ena) begin
      phase <= phase + 1'b1;
      if (dwell_end) ptr <= frame_wrap ? '0 : ptr + 1'b1;
      if (frame_wrap) begin
        frame_cnt   <= frame_cnt + 1'b1;
        snap.bcd    <= bus.digits_bcd;
        snap.dp     <= bus.dp_mask;
        snap.blink  <= bus.blink_mask;
        snap.lz     <= bus.lz_en;
        snap.bright <= bus.brightness;
      end
    end
  end

  // Priority chain from the most significant digit: zero_from[i] means digits i..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (snap.bcd[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (snap.bcd[4*i +: 4] == 4'd0);
    end
  end

  // Digit 0 always shows so an all-zero value still renders a single 0.
  assign lz_mask = snap.lz ? {zero_from[DIGITS-1:1], 1'b0} : '0;

  // Select the digit at the current position; position 0 is the leftmost (most significant) digit.
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(ptr) == DIGITS - 1 - i) begin
        cur_bcd   = snap.bcd[4*i +: 4];
        cur_dp    = snap.dp[i];
        cur_blink = snap.blink[i];
        cur_lz    = lz_mask[i];
      end
    end
  end

  seg_scan_mux_bcd_to_seg u_bcd_to_seg (
    .bcd   (cur_bcd),
    .glyph (cur_glyph)
  );

  // PWM off-time and the blink off-half blank both segments and dp; LZ blanks segments only.
  assign visible = (phase <= snap.bright) && !(cur_blink && frame_cnt[BLINK_BITS-1]);

  // Output register; frame_tick fires on the first enabled output after a wrap.
  always_ff @(posedge clk_scan_to_light or posedge rst) begin
    if (rst) begin
      sel_q        <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      wrap_pend    <= 1'b0;
    end else begin
      frame_tick_q <= bus.ena && wrap_pend;
      if (frame_wrap)   wrap_pend <= 1'b1;
      else if (bus.ena) wrap_pend <= 1'b0;
      if (bus.ena) begin
        sel_q <= ptr;
        seg_q <= (visible && !cur_lz) ? cur_glyph : SEG_BLANK;
        dp_q  <= visible && cur_dp;
      end else begin
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b0;
      end
    end
  end

  assign bus.sel        = sel_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
